// File: rtl/rmc_req_arbiter_pkg.sv
// Shared types for the request-FIFO arbiter in front of cpu_rmc.
// Holds the header layout, the FSM encoding and a header-building helper.
package rmc_req_arbiter_pkg;

    localparam int CPU_DATA_WIDTH = 32;
    localparam int MAX_REQ_WORDS  = 8;
    localparam int REQ_LEN_W      = $clog2(MAX_REQ_WORDS + 1);

    typedef struct packed {
        logic [CPU_DATA_WIDTH-REQ_LEN_W-1:0] rsvd;
        logic [REQ_LEN_W-1:0]                len;
    } req_hdr_t;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY
    } arb_state_e;

    function automatic logic [CPU_DATA_WIDTH-1:0] mk_req_hdr(
        input logic [CPU_DATA_WIDTH-REQ_LEN_W-1:0] rsvd,
        input logic [REQ_LEN_W-1:0]                len
    );
        req_hdr_t h;
        h.rsvd = rsvd;
        h.len  = len;
        return h;
    endfunction

endpackage

// File: rtl/rmc_req_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the request arbiter.
// master = requesters + FIFO model, slave = the arbiter.
interface rmc_req_arbiter_if
    import rmc_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = CPU_DATA_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         fifo_data_in;
    logic                     fifo_enq;
    logic                     fifo_wrfull;
    logic [ID_W-1:0]          grant_id;
    logic                     busy;
    logic                     len_err;

    modport master (
        output req_valid, req_data, fifo_wrfull,
        input  req_ready, fifo_data_in, fifo_enq, grant_id, busy, len_err
    );

    modport slave (
        input  req_valid, req_data, fifo_wrfull,
        output req_ready, fifo_data_in, fifo_enq, grant_id, busy, len_err
    );
endinterface

// File: rtl/rmc_req_arbiter_rr_pick.sv
// Round-robin picker: first set bit of valid at or above ptr, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
module rmc_req_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    // Scan from the farthest offset down so the nearest valid index wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            int cand;
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (valid[cand]) begin
                found = 1'b1;
                idx   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/rmc_req_arbiter.sv
// Packet-locked round-robin arbiter sharing one request FIFO among NUM_REQ requesters.
// Latency: 1 arbitration cycle, then one word per cycle with zero-latency pass-through.
// Backpressure: fifo_wrfull drops req_ready/fifo_enq in the same cycle; valid drops make bubbles.
module rmc_req_arbiter
    import rmc_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = CPU_DATA_WIDTH,
    parameter int MAX_WORDS = MAX_REQ_WORDS
) (
    input  logic              clk,
    input  logic              rstn,
    rmc_req_arbiter_if.slave  bus
);

    localparam int LEN_W = $clog2(MAX_WORDS + 1);
    localparam int ID_W  = $clog2(NUM_REQ);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             len_err_q, len_err_d;

    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic             busy_w;
    logic             beat;
    logic [WIDTH-1:0] gnt_word;
    logic [LEN_W-1:0] hdr_len;
    logic [ID_W-1:0]  next_ptr;
    logic [NUM_REQ-1:0] ready_w;

    rmc_req_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy_w   = (state_q != IDLE);
    assign gnt_word = bus.req_data[grant_id_q*WIDTH +: WIDTH];
    assign hdr_len  = gnt_word[LEN_W-1:0];
    assign beat     = busy_w && bus.req_valid[grant_id_q] && !bus.fifo_wrfull;
    assign next_ptr = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

    always_comb begin
        ready_w = '0;
        if (busy_w && !bus.fifo_wrfull) ready_w[grant_id_q] = 1'b1;
    end

    assign bus.req_ready    = ready_w;
    assign bus.fifo_enq     = beat;
    assign bus.fifo_data_in = busy_w ? gnt_word : '0;
    assign bus.grant_id     = grant_id_q;
    assign bus.busy         = busy_w;
    assign bus.len_err      = len_err_q;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        len_err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    state_d    = HDR;
                end
            end
            HDR: begin
                if (beat) begin
                    if (hdr_len == '0) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end else if (hdr_len > LEN_W'(MAX_WORDS)) begin
                        // Oversized header is still forwarded; only MAX_WORDS payload words follow.
                        cnt_d     = LEN_W'(MAX_WORDS);
                        len_err_d = 1'b1;
                        state_d   = PAY;
                    end else begin
                        cnt_d   = hdr_len;
                        state_d = PAY;
                    end
                end
            end
            PAY: begin
                if (beat) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            len_err_q  <= len_err_d;
        end
    end

endmodule

// File: tb/tb_rmc_req_arbiter.sv
// Directed bench for rmc_req_arbiter: per-requester word queues feed the DUT and a
// scoreboard of expected (id, word) pairs is popped on every fifo_enq.
module tb_rmc_req_arbiter;
    import rmc_req_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int W  = 32;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] w;
    } exp_t;

    logic clk;
    logic rstn;

    rmc_req_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ID_W(2)) bus ();

    rmc_req_arbiter #(
        .NUM_REQ   (NR),
        .WIDTH     (W),
        .MAX_WORDS (8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] src_q[NR][$];
    exp_t        exp_q[$];
    int          checks;
    int          passes;
    int          enq_cnt;
    int          lerr_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [NR*W-1:0] d;
        logic [NR-1:0]   v;
        d = '0;
        v = '0;
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                v[i]         = 1'b1;
                d[i*W +: W]  = src_q[i][0];
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
    endtask

    task automatic send(input int id, input int len, input logic [31:0] base);
        logic [31:0] w;
        int          n;
        w = mk_req_hdr(28'(32'h00C0DE0 + id), 4'(len));
        src_q[id].push_back(w);
        exp_q.push_back('{id: 2'(id), w: w});
        n = (len > 8) ? 8 : len;
        for (int k = 0; k < n; k++) begin
            w = base + 32'(k);
            src_q[id].push_back(w);
            exp_q.push_back('{id: 2'(id), w: w});
        end
    endtask

    // One clock: sample at the falling edge, then update stimulus just after the rising edge.
    task automatic step();
        logic [NR-1:0] acc;
        exp_t          e;
        @(negedge clk);
        if (bus.busy && !bus.fifo_wrfull && exp_q.size() > 0)
            check("ready_gnt", bus.req_ready, 4'b0001 << exp_q[0].id);
        else
            check("ready_off", bus.req_ready, 0);
        if (bus.fifo_wrfull) check("enq_while_full", bus.fifo_enq, 0);
        if (exp_q.size() == 0) begin
            check("no_spurious_enq", bus.fifo_enq, 0);
        end else if (bus.fifo_enq) begin
            e = exp_q.pop_front();
            check("enq_word", bus.fifo_data_in, e.w);
            check("enq_gid", bus.grant_id, e.id);
            check("enq_busy", bus.busy, 1);
        end
        if (bus.fifo_enq) enq_cnt++;
        if (bus.len_err) lerr_cnt++;
        acc = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 200) begin
            step();
            n++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic steps_until_enq(input string tag, input int target);
        int base;
        int n;
        base = enq_cnt;
        n    = 0;
        while (enq_cnt - base < target && n < 50) begin
            step();
            n++;
        end
        check(tag, enq_cnt - base, target);
    endtask

    initial begin
        int n;
        int e0;
        int l0;
        checks        = 0;
        passes        = 0;
        enq_cnt       = 0;
        lerr_cnt      = 0;
        rstn          = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_wrfull = 1'b0;
        #1;
        check("rst_ready", bus.req_ready, 0);
        check("rst_enq", bus.fifo_enq, 0);
        check("rst_data", bus.fifo_data_in, 0);
        check("rst_gid", bus.grant_id, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_len_err", bus.len_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single requester, L=3: 1 arbitration cycle + 4 back-to-back beats.
        e0 = enq_cnt;
        l0 = lerr_cnt;
        send(1, 3, 32'hA1);
        drive();
        wait_idle("single", n);
        check("single_cycles", n, 5);
        check("single_words", enq_cnt - e0, 4);
        check("single_no_len_err", lerr_cnt - l0, 0);

        // Zero-length packet on req3: header only.
        e0 = enq_cnt;
        send(3, 0, 32'h0);
        drive();
        wait_idle("len0", n);
        check("len0_cycles", n, 2);
        check("len0_words", enq_cnt - e0, 1);
        check("len0_ptr", dut.rr_ptr_q, 0);

        // All four requesters at once, L=2 each: order 0,1,2,3 in 16 cycles.
        for (int i = 0; i < NR; i++) send(i, 2, 32'h100 * (i + 1));
        drive();
        wait_idle("all4", n);
        check("all4_cycles", n, 16);
        check("all4_ptr", dut.rr_ptr_q, 0);

        // Fairness: req0 re-requests immediately while req2 waits -> 0,2,0,2.
        send(0, 1, 32'hF00);
        send(2, 1, 32'hF20);
        send(0, 1, 32'hF01);
        send(2, 1, 32'hF21);
        drive();
        wait_idle("fair", n);
        check("fair_ptr", dut.rr_ptr_q, 3);

        // Backpressure: 5 full cycles inside an L=4 packet.
        e0 = enq_cnt;
        send(3, 4, 32'hB0);
        drive();
        steps_until_enq("bp_pre", 2);
        bus.fifo_wrfull = 1'b1;
        n = enq_cnt;
        repeat (5) step();
        check("bp_stall_words", enq_cnt - n, 0);
        bus.fifo_wrfull = 1'b0;
        wait_idle("bp", n);
        check("bp_words", enq_cnt - e0, 5);

        // Oversized header: L=12 clamps to 8 payload words, one len_err pulse.
        e0 = enq_cnt;
        l0 = lerr_cnt;
        send(0, 12, 32'hC0);
        drive();
        wait_idle("ovf", n);
        check("ovf_words", enq_cnt - e0, 9);
        check("ovf_len_err", lerr_cnt - l0, 1);

        // Reset after header + 2 payload words of an L=5 packet.
        send(2, 5, 32'hD0);
        drive();
        steps_until_enq("rst_pre", 3);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_ready", bus.req_ready, 0);
        check("mid_rst_enq", bus.fifo_enq, 0);
        check("mid_rst_data", bus.fifo_data_in, 0);
        check("mid_rst_gid", bus.grant_id, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_len_err", bus.len_err, 0);
        for (int i = 0; i < NR; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        @(negedge clk);
        rstn = 1'b1;
        check("post_rst_ptr", dut.rr_ptr_q, 0);
        @(posedge clk);
        #1;
        send(3, 0, 32'h0);
        drive();
        step();
        check("post_rst_gid", bus.grant_id, 3);
        check("post_rst_busy", bus.busy, 1);
        wait_idle("post_rst", n);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rmc_req_arbiter.md
Name: rmc_req_arbiter

Overview:
- Shares the single request FIFO in front of `cpu_rmc` (the `fifo_ack` write interface: `data_in`/`enq`/`wrfull`) among `NUM_REQ` independent requesters.
- Each request is a packet: one header word carrying a payload length, followed by that many payload words.
- The arbiter grants round-robin and holds the grant until the whole packet is enqueued, so packets from different requesters never interleave in the FIFO.

Parameters:
- `NUM_REQ`, 4, number of requesters (2..8).
- `WIDTH`, `cpuPkg::CPU_DATA_WIDTH`, word width of the request FIFO.
- `MAX_WORDS`, 8, maximum payload words per packet.
- `LEN_W`, `$clog2(MAX_WORDS+1)`, width of the header length field (derived; do not override).
- `ID_W`, `$clog2(NUM_REQ)`, width of the grant index (derived).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  per-requester word valid.
- `req_data`  in  `NUM_REQ*WIDTH`  flattened words; requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  `NUM_REQ`  per-requester word accepted (one-hot or zero).
- `fifo_data_in`  out  `WIDTH`  word to the request FIFO.
- `fifo_enq`  out  1  request-FIFO write strobe.
- `fifo_wrfull`  in  1  request-FIFO full.
- `grant_id`  out  `ID_W`  index of the locked requester; valid while `busy`.
- `busy`  out  1  a packet is locked.
- `len_err`  out  1  one-cycle pulse when a header length exceeds `MAX_WORDS`.

Behaviour:
- Reset values: `req_ready`=0, `fifo_enq`=0, `fifo_data_in`=0, `grant_id`=0, `busy`=0, `len_err`=0, FSM=IDLE, RR pointer=0, word counter=0.
- Header format: `hdr[LEN_W-1:0]` is the payload length L (0..`MAX_WORDS`). Upper bits pass through untouched.
- Transfer rule: beat on requester g occurs when `busy && req_valid[g] && !fifo_wrfull`.
  - `req_ready[g] = busy && !fifo_wrfull`; all other `req_ready` bits are 0.
  - `fifo_enq` = the beat condition.
  - `fifo_data_in = req_data[g]`.
  - These outputs are combinational from registered state, with zero-latency pass-through.
- FSM states:
  - IDLE:
    - `busy`=0, no ready asserted.
    - If any `req_valid`, pick the first valid index scanning from the RR pointer upward with wrap.
    - Register it into `grant_id`, then go to HDR next cycle (1-cycle arbitration bubble).
  - HDR:
    - On a beat, capture L into the counter.
    - L=0 → IDLE. L in 1..`MAX_WORDS` → PAY.
    - L>`MAX_WORDS` → pulse `len_err` the next cycle, load counter with `MAX_WORDS`, go to PAY. The header is forwarded unmodified.
  - PAY:
    - Each beat decrements the counter.
    - The beat with counter==1 is the last word → IDLE.
- RR update: when leaving HDR/PAY for IDLE, pointer ← `grant_id`+1 mod `NUM_REQ`. The pointer is unchanged otherwise.
- A requester dropping `req_valid` mid-packet causes bubble cycles. The lock is held indefinitely with no timeout.
- `fifo_wrfull` stalls in any state; no word is lost or duplicated.
- Valid on non-granted requesters is ignored while `busy`; their `req_ready` stays 0.
- Simultaneous packet completion and new requests: the new arbitration happens in the IDLE cycle after completion.
- Throughput:
  - Packet with L payload words, no stalls: L+1 transfer cycles plus 1 IDLE cycle.
  - Back-to-back `NUM_REQ`=4 packets of L=2 take 16 cycles.
- Reset mid-packet: immediate return to reset values. Words already enqueued stay in the FIFO; the FIFO is reset separately by the same `rstn`.

Decomposition:
- `cpuPkg` additions:
  - `REQ_LEN_W` constant.
  - `MAX_REQ_WORDS`=8 constant.
  - `req_hdr_t` packed struct (`rsvd`, `len`).
  - `arb_state_e` enum {IDLE, HDR, PAY}.
- One sub-module: `rr_pick` (combinational, parameterised by `NUM_REQ`). Inputs are the valid vector and pointer; outputs are the found flag and index.
- The FSM, counter and muxing stay in `rmc_req_arbiter`.

Test Plan:
- Single requester: req1 sends hdr L=3 then 0xA1, 0xA2, 0xA3, FIFO never full → FIFO receives the header word then 0xA1..0xA3 on 4 consecutive cycles. `grant_id`=1 and `busy`=1 for those cycles; `busy` returns to 0 on the next cycle.
- All 4 requesters valid at once, each with L=2 → packets are enqueued in order 0, 1, 2, 3, never interleaved. 16 cycles total; RR pointer=0 at the end.
- Fairness: req0 continuously re-requests while req2 is pending → grant order 0, 2, 0, 2.
- Backpressure: `fifo_wrfull` asserted for 5 cycles in the middle of an L=4 packet → `fifo_enq`=0 and `req_ready`=0 during those cycles; the word sequence is intact afterwards.
- Header L=0 → one enq, then IDLE. Header L=12 with `MAX_WORDS`=8 → `len_err` pulses once; exactly 9 words are enqueued.
- `rstn` asserted after 2 payload words of an L=5 packet → all outputs are 0 asynchronously. After release with req3 valid, `grant_id`=3 (pointer is 0, and req3 is the only valid requester).
